ex_mem_stage: RTL

Memory-stage block of the 5-stage pipeline. It sits directly downstream of the ID/EX register and the ALU. It latches EX results into an EX/MEM register and drives the one-way data cache request/stall handshake. It also produces the MEM/WB register for write-back, freezes upstream stages on a cache miss, and keeps saturating access and miss counters.

---
 rtl/ex_mem_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register, data cache handshake, MEM/WB register
// and saturating access/miss counters; all flops use the falling edge.
module ex_mem_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [1:0]       wb_i,
  input  logic [1:0]       mem_i,
  input  logic [31:0]      alu_i,
  input  logic [31:0]      wdata_i,
  input  logic [4:0]       rdaddr_i,
  output logic             dc_req_o,
  output logic             dc_we_o,
  output logic [31:0]      dc_addr_o,
  output logic [31:0]      dc_wdata_o,
  input  logic [31:0]      dc_rdata_i,
  input  logic             dc_stall_i,
  output logic             stall_o,
  output logic             exmem_regwrite_o,
  output logic [4:0]       exmem_rdaddr_o,
  output logic [1:0]       wb_o,
  output logic [31:0]      rdata_o,
  output logic [31:0]      alu_o,
  output logic [4:0]       rdaddr_o,
  output logic [CNT_W-1:0] acc_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  mem;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  rdaddr;
  } ex_mem_t;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  ex_mem_t q;
  state_t  st;
  state_t  st_nx;
  logic    mop;
  logic    ld;
  logic    acc_inc;
  logic    miss_inc;

  assign mop        = q.mem[1] | q.mem[0];
  // Read+write together behaves as a store, so only a pure read loads.
  assign ld         = q.mem == 2'b01;
  assign dc_req_o   = mop;
  assign dc_we_o    = q.mem[1];
  assign dc_addr_o  = q.alu;
  assign dc_wdata_o = q.wdata;
  assign stall_o    = mop & dc_stall_i;
  assign acc_inc    = mop & ~dc_stall_i;

  assign exmem_regwrite_o = q.wb[1];
  assign exmem_rdaddr_o   = q.rdaddr;

  always_ff @(negedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!stall_o) begin
      q <= '{wb: wb_i, mem: mem_i, alu: alu_i,
             wdata: wdata_i, rdaddr: rdaddr_i};
    end
  end

  always_ff @(negedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
    end else begin
      st <= st_nx;
    end
  end

  always_comb begin
    st_nx    = st;
    miss_inc = 1'b0;
    unique case (st)
      IDLE: begin
        if (mop && dc_stall_i) begin
          st_nx    = MISS;
          miss_inc = 1'b1;
        end
      end
      MISS: begin
        if (!dc_stall_i) begin
          st_nx = IDLE;
        end
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(negedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (acc_inc && acc_cnt_o != '1) begin
        acc_cnt_o <= acc_cnt_o + 1'b1;
      end
      if (miss_inc && miss_cnt_o != '1) begin
        miss_cnt_o <= miss_cnt_o + 1'b1;
      end
    end
  end

  always_ff @(negedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wb_o     <= '0;
      rdata_o  <= '0;
      alu_o    <= '0;
      rdaddr_o <= '0;
    end else if (stall_o) begin
      wb_o <= 2'b00;
    end else begin
      wb_o     <= q.wb;
      alu_o    <= q.alu;
      rdaddr_o <= q.rdaddr;
      if (ld) begin
        rdata_o <= dc_rdata_i;
      end
    end
  end

endmodule
